// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and write-back record for the Kyber NTT datapath.
package ntt_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int NTT_STAGES = 7;
  localparam int LOG_N      = 8;
  localparam int ROM_LAT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } wb_t;

endpackage

// File: rtl/ntt_delay_line.sv
// DEPTH x WIDTH shift register with enable; output is the last stage register.
module ntt_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Forward Kyber NTT sequencer: one butterfly issue per cycle, write-back addresses
// delayed by LAT, inter-stage drain so the next stage never reads stale data.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int BF_LAT  = 4,
  parameter int TW_BASE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic [2:0] stage
);

  localparam int         LAT        = BF_LAT + ROM_LAT;
  // Counter is loaded with LAT-1 and the stage advances on the cycle it reads 0,
  // giving exactly LAT idle cycles between stages.
  localparam logic [3:0] DRAIN_LAST = 4'(LAT - 1);
  localparam logic [6:0] TW_OFS     = 7'(TW_BASE - 1);
  localparam logic [2:0] LAST_STAGE = 3'(NTT_STAGES - 1);

  state_t     state, state_nxt;
  logic [2:0] s, s_nxt;
  logic [6:0] i, i_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [3:0] sh_g, sh_a;
  logic [7:0] len, g, off, a_nxt, b_nxt;
  logic [6:0] tw_nxt;
  logic       run_nxt;
  wb_t        wb_in, wb_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      s     <= '0;
      i     <= '0;
      cnt   <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      s     <= s_nxt;
      i     <= i_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    i_nxt     = i;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          s_nxt     = '0;
          i_nxt     = '0;
        end
      end
      ST_RUN: begin
        i_nxt = i + 7'd1;
        if (i == 7'd127) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LAST;
        end
      end
      ST_DRAIN: begin
        if (cnt == 4'd0) begin
          if (s == LAST_STAGE) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_RUN;
            s_nxt     = s + 3'd1;
            i_nxt     = '0;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        s_nxt     = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Addresses are computed for the upcoming cycle so they can be registered.
  always_comb begin
    sh_g    = 4'd7 - {1'b0, s_nxt};
    sh_a    = 4'd8 - {1'b0, s_nxt};
    len     = 8'd128 >> s_nxt;
    g       = {1'b0, i_nxt} >> sh_g;
    off     = {1'b0, i_nxt} & (len - 8'd1);
    a_nxt   = (g << sh_a) + off;
    b_nxt   = a_nxt + len;
    tw_nxt  = TW_OFS + (7'd1 << s_nxt) + g[6:0];
    run_nxt = (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
    end else if (!stall) begin
      rd_en     <= run_nxt;
      rd_addr_a <= run_nxt ? a_nxt : 8'd0;
      rd_addr_b <= run_nxt ? b_nxt : 8'd0;
      tw_addr   <= run_nxt ? tw_nxt : 7'd0;
      busy      <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done      <= (state_nxt == ST_FIN);
      stage     <= s_nxt;
    end
  end

  assign wb_in = '{vld: rd_en, a: rd_addr_a, b: rd_addr_b};

  ntt_delay_line #(
    .DEPTH (LAT),
    .WIDTH ($bits(wb_t))
  ) u_wb_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (!stall),
    .din  (wb_in),
    .dout (wb_out)
  );

  assign wr_en     = wb_out.vld;
  assign wr_addr_a = wb_out.a;
  assign wr_addr_b = wb_out.b;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed bench for ntt_addr_gen (BF_LAT=4, TW_BASE=1) with a Kyber loop-nest reference.
module tb_ntt_addr_gen;

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;
  logic [2:0] stage;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] ref_a [896];
  logic [7:0] ref_b [896];
  logic [6:0] ref_k [896];

  ntt_addr_gen #(.BF_LAT(4), .TW_BASE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // After each call the visible outputs belong to cycle 'cyc'.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic full_run();
    int rd_n, wr_n, done_n, done_cyc, bad;
    int iss [896];
    int seen [7][256];
    rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; bad = 0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 940) begin
      if (rd_en) begin
        if (rd_n < 896) begin
          chk("sb_rd", {rd_addr_a, rd_addr_b, tw_addr}, {ref_a[rd_n], ref_b[rd_n], ref_k[rd_n]});
          iss[rd_n] = cyc;
          if (stage < 3'd7) begin
            seen[stage][rd_addr_a]++;
            seen[stage][rd_addr_b]++;
          end
        end
        rd_n++;
      end
      if (wr_en) begin
        if (wr_n < 896) begin
          chk("sb_wr", {wr_addr_a, wr_addr_b}, {ref_a[wr_n], ref_b[wr_n]});
          chk("wr_lat", cyc - iss[wr_n], 5);
        end
        wr_n++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      case (cyc)
        1: begin
          chk("c1_rd_en", rd_en, 1);
          chk("c1_addr", {rd_addr_a, rd_addr_b, tw_addr}, {8'd0, 8'd128, 7'd1});
          chk("c1_busy", busy, 1);
        end
        5: chk("c5_wr_en", wr_en, 0);
        6: begin
          chk("c6_wr_en", wr_en, 1);
          chk("c6_wr_addr", {wr_addr_a, wr_addr_b}, {8'd0, 8'd128});
        end
        128: chk("c128_addr", {rd_addr_a, rd_addr_b, tw_addr}, {8'd127, 8'd255, 7'd1});
        129, 130, 131, 132, 133: chk("drain_rd_en", rd_en, 0);
        134: begin
          chk("c134_stage", stage, 1);
          chk("c134_addr", {rd_addr_a, rd_addr_b, tw_addr}, {8'd0, 8'd64, 7'd2});
        end
        198: chk("c198_addr", {rd_addr_a, rd_addr_b, tw_addr}, {8'd128, 8'd192, 7'd3});
        926: chk("c926_addr", {rd_addr_a, rd_addr_b, tw_addr}, {8'd253, 8'd255, 7'd127});
        931: begin
          chk("c931_wr_en", wr_en, 1);
          chk("c931_done", done, 0);
        end
        932: begin
          chk("c932_done", done, 1);
          chk("c932_busy", busy, 0);
          chk("c932_wr_en", wr_en, 0);
        end
        933: chk("c933_done", done, 0);
        default: ;
      endcase
      tick();
    end
    for (int s = 0; s < 7; s++)
      for (int a = 0; a < 256; a++)
        if (seen[s][a] != 1) bad++;
    chk("rd_count", rd_n, 896);
    chk("wr_count", wr_n, 896);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_cyc, 932);
    chk("once_per_stage", bad, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic stall_run();
    int done_n, done_cyc;
    done_n = 0; done_cyc = -1;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 950) begin
      stall = (cyc >= 50 && cyc <= 52);
      if (cyc >= 50 && cyc <= 53) begin
        chk("stall_rd", {rd_en, rd_addr_a, rd_addr_b, tw_addr}, {1'b1, 8'd49, 8'd177, 7'd1});
        chk("stall_wr", {wr_en, wr_addr_a, wr_addr_b}, {1'b1, 8'd44, 8'd172});
      end
      if (cyc == 54)
        chk("stall_resume", {rd_addr_a, rd_addr_b, tw_addr}, {8'd50, 8'd178, 7'd1});
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      tick();
    end
    stall = 1'b0;
    chk("stall_done_count", done_n, 1);
    chk("stall_done_cycle", done_cyc, 935);
  endtask

  task automatic restart_reset_run();
    int done_n, wr_n;
    done_n = 0; wr_n = 0;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 400) begin
      start = (cyc == 300);
      tick();
      if (cyc == 301) begin
        chk("repulse_stage", stage, 2);
        chk("repulse_addr", {rd_addr_a, rd_addr_b, tw_addr}, {8'd66, 8'd98, 7'd5});
        chk("repulse_busy", busy, 1);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ctl", {rd_en, wr_en, busy, done, stage}, 0);
    chk("rst_rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, 0);
    chk("rst_wr_addr", {wr_addr_a, wr_addr_b}, 0);
    repeat (20) begin
      tick();
      if (done) done_n++;
      if (wr_en) wr_n++;
    end
    chk("rst_no_done", done_n, 0);
    chk("rst_no_wr", wr_n, 0);
    chk("rst_idle_busy", busy, 0);
  endtask

  initial begin
    int n, k;
    n = 0;
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ref_a[n] = 8'(j);
          ref_b[n] = 8'(j + len);
          ref_k[n] = 7'(k);
          n++;
        end
        k++;
      end
    end

    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ctl", {rd_en, wr_en, busy, done, stage}, 0);
    chk("reset_rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, 0);
    chk("reset_wr_addr", {wr_addr_a, wr_addr_b}, 0);

    full_run();
    stall_run();
    restart_reset_run();
    full_run();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
